// File: rtl/cpu_if_mc.sv
// CPU register interface for a multi-channel datapath: global control/status,
// W1C interrupt and error status, per-channel start/busy tracking and config banks.
module cpu_if_mc #(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned REGS_PER_CH = 8,
  parameter int unsigned ADR_W       = 10,
  parameter logic [31:0] VERSION     = 32'h0002_0000
) (
  input  logic                            i_clk,
  input  logic                            i_reset,
  input  logic [ADR_W-1:0]                i_adr,
  input  logic                            i_wr,
  input  logic [31:0]                     i_wdata,
  input  logic                            i_rd,
  output logic [31:0]                     o_rdata,
  output logic                            o_int,
  output logic                            o_soft_reset,
  output logic [N_CH-1:0]                 o_start,
  input  logic [N_CH-1:0]                 i_finish,
  output logic [N_CH*REGS_PER_CH*32-1:0]  o_cfg
);

  localparam int unsigned N_REGS = N_CH * REGS_PER_CH;
  localparam int unsigned CFG_W  = N_REGS * 32;
  localparam int unsigned CH_AW  = ADR_W - 6;

  logic [CFG_W-1:0]  r_cfg;
  logic [N_CH-1:0]   r_busy;
  logic [N_CH-1:0]   r_int_stat;
  logic [N_CH-1:0]   r_int_en;
  logic [N_CH-1:0]   r_err_ovr;
  logic [N_CH-1:0]   r_err_cfg;
  logic [N_CH-1:0]   r_start;
  logic [31:0]       r_rdata;
  logic              r_int;
  logic              r_soft_reset;

  logic              w_glb;
  logic [5:0]        w_glb_word;
  logic [CH_AW-1:0]  w_ch_blk;
  logic [3:0]        w_reg;
  logic              w_glb_wr;
  logic              w_wr_ctrl;
  logic              w_wr_istat;
  logic              w_wr_ien;
  logic              w_wr_start;
  logic              w_wr_err;
  logic              w_soft;
  logic [N_CH-1:0]   w_start_req;
  logic [N_CH-1:0]   w_start_ok;
  logic [N_CH-1:0]   w_start_ovr;
  logic [N_CH-1:0]   w_fin;
  logic [N_CH-1:0]   w_istat_clr;
  logic [N_CH-1:0]   w_err_clr_lo;
  logic [N_CH-1:0]   w_err_clr_hi;
  logic [N_CH-1:0]   w_cfg_busy;
  logic [N_REGS-1:0] w_cfg_we;
  logic [31:0]       w_cfg_rd;
  logic [31:0]       w_err32;
  logic [31:0]       w_rdata;
  logic              w_unused_adr;

  assign w_unused_adr = ^i_adr[1:0];

  // Global registers live below 0x100; channel banks start at block 4 (0x100).
  assign w_glb      = (i_adr[ADR_W-1:8] == '0);
  assign w_glb_word = i_adr[7:2];
  assign w_ch_blk   = i_adr[ADR_W-1:6];
  assign w_reg      = i_adr[5:2];

  assign w_glb_wr   = i_wr & w_glb;
  assign w_wr_ctrl  = w_glb_wr && (w_glb_word == 6'd0);
  assign w_wr_istat = w_glb_wr && (w_glb_word == 6'd2);
  assign w_wr_ien   = w_glb_wr && (w_glb_word == 6'd3);
  assign w_wr_start = w_glb_wr && (w_glb_word == 6'd4);
  assign w_wr_err   = w_glb_wr && (w_glb_word == 6'd5);
  assign w_soft     = w_wr_ctrl & i_wdata[0];

  // Busy is evaluated before the edge, so a same-cycle finish does not admit a start.
  assign w_start_req  = w_wr_start ? i_wdata[N_CH-1:0] : '0;
  assign w_start_ok   = w_start_req & ~r_busy;
  assign w_start_ovr  = w_start_req & r_busy;
  assign w_fin        = i_finish & r_busy;
  assign w_istat_clr  = w_wr_istat ? i_wdata[N_CH-1:0] : '0;
  assign w_err_clr_lo = w_wr_err ? i_wdata[N_CH-1:0] : '0;
  assign w_err_clr_hi = w_wr_err ? i_wdata[8 +: N_CH] : '0;

  // Channel bank decode: read data, write enables and config-while-busy errors.
  always_comb begin
    w_cfg_rd   = '0;
    w_cfg_we   = '0;
    w_cfg_busy = '0;
    for (int c = 0; c < N_CH; c++) begin
      for (int r = 0; r < REGS_PER_CH; r++) begin
        if ((w_ch_blk == CH_AW'(c + 4)) && (w_reg == 4'(r))) begin
          w_cfg_rd = r_cfg[(c*REGS_PER_CH + r)*32 +: 32];
          if (i_wr) begin
            if (r_busy[c]) begin
              w_cfg_busy[c] = 1'b1;
            end else begin
              w_cfg_we[c*REGS_PER_CH + r] = 1'b1;
            end
          end
        end
      end
    end
  end

  assign w_err32 = 32'(r_err_ovr) | (32'(r_err_cfg) << 8);

  always_comb begin
    w_rdata = '0;
    if (w_glb) begin
      case (w_glb_word)
        6'd1:    w_rdata = 32'(r_busy);
        6'd2:    w_rdata = 32'(r_int_stat);
        6'd3:    w_rdata = 32'(r_int_en);
        6'd5:    w_rdata = w_err32;
        6'd6:    w_rdata = VERSION;
        default: w_rdata = '0;
      endcase
    end else begin
      w_rdata = w_cfg_rd;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cfg        <= '0;
      r_busy       <= '0;
      r_int_stat   <= '0;
      r_int_en     <= '0;
      r_err_ovr    <= '0;
      r_err_cfg    <= '0;
      r_start      <= '0;
      r_rdata      <= '0;
      r_int        <= 1'b0;
      r_soft_reset <= 1'b0;
    end else begin
      r_soft_reset <= w_soft;
      r_int        <= |(r_int_stat & r_int_en);
      if (i_rd) begin
        r_rdata <= w_rdata;
      end
      if (w_wr_ien) begin
        r_int_en <= i_wdata[N_CH-1:0];
      end
      for (int i = 0; i < N_REGS; i++) begin
        if (w_cfg_we[i]) begin
          r_cfg[i*32 +: 32] <= i_wdata;
        end
      end
      // Soft reset wipes channel activity but keeps configuration and enables.
      if (w_soft) begin
        r_busy     <= '0;
        r_int_stat <= '0;
        r_err_ovr  <= '0;
        r_err_cfg  <= '0;
        r_start    <= '0;
      end else begin
        r_start    <= w_start_ok;
        r_busy     <= (r_busy & ~w_fin) | w_start_ok;
        r_int_stat <= (r_int_stat & ~w_istat_clr) | w_fin;
        r_err_ovr  <= (r_err_ovr & ~w_err_clr_lo) | w_start_ovr;
        r_err_cfg  <= (r_err_cfg & ~w_err_clr_hi) | w_cfg_busy;
      end
    end
  end

  assign o_rdata      = r_rdata;
  assign o_int        = r_int;
  assign o_soft_reset = r_soft_reset;
  assign o_start      = r_start;
  assign o_cfg        = r_cfg;

endmodule

// File: doc/cpu_if_mc.md
CPU_IF_MC -- requirements
Module: cpu_if_mc

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of independent operation channels (1..8).
REQ-002 SHALL have parameter REGS_PER_CH, default 8, number of 32-bit config registers per channel (1..16).
REQ-003 SHALL have parameter ADR_W, default 10, byte-address width (>=10).
REQ-004 SHALL have parameter VERSION, default 32'h0002_0000, value returned by the VERSION register.
REQ-005 CLK  in  1  clock; one clock domain, all state on rising edge.
REQ-006 RESET  in  1  reset, synchronous, active-high.
REQ-007 ADR  in  ADR_W  byte address; ADR[1:0] ignored.
REQ-008 WR  in  1  write strobe, one access per cycle.
REQ-009 WDATA  in  32  write data.
REQ-010 RD  in  1  read strobe.
REQ-011 RDATA  out  32  registered read data.
REQ-012 INT  out  1  level interrupt, registered.
REQ-013 SOFT_RESET  out  1  one-cycle pulse to datapath.
REQ-014 START  out  N_CH  per-channel one-cycle start pulse.
REQ-015 FINISH  in  N_CH  per-channel one-cycle completion pulse from datapath.
REQ-016 CFG  out  N_CH*REGS_PER_CH*32  flat config bus; channel c register r at bits [(c*REGS_PER_CH+r)*32 +: 32].

Function
REQ-017 Global map SHALL be: 0x000 CTRL (W, bit0 soft reset), 0x004 STATUS (R, [N_CH-1:0] busy), 0x008 INT_STAT (R/W1C), 0x00C INT_EN (R/W), 0x010 START (W, bit c starts channel c), 0x014 ERR_STAT (R/W1C), 0x018 VERSION (RO).
REQ-018 Channel register r of channel c SHALL be at 0x100 + c*0x40 + r*4; R/W; r >= REGS_PER_CH or c >= N_CH unmapped.
REQ-019 Reads of unmapped addresses SHALL return 0; writes to unmapped or RO addresses SHALL have no effect.
REQ-020 Read latency SHALL be 1 cycle: RDATA valid cycle after RD; RDATA holds its value when RD low.
REQ-021 RD and WR to the same address in the same cycle SHALL return the pre-write value.
REQ-022 Write to START with bit c set and busy[c]=0 SHALL assert START[c] next cycle for exactly 1 cycle and set busy[c] on that same edge.
REQ-023 Write to START with bit c set and busy[c]=1 SHALL not pulse START[c] and SHALL set ERR_STAT[c] (start overrun).
REQ-024 Write to any config register of channel c while busy[c]=1 SHALL be discarded and SHALL set ERR_STAT[8+c] (config-while-busy).
REQ-025 FINISH[c] while busy[c]=1 SHALL clear busy[c] and set INT_STAT[c] on the next edge.
REQ-026 FINISH[c] while busy[c]=0 SHALL be ignored (no status change).
REQ-027 FINISH[c] and START write for channel c in the same cycle SHALL evaluate busy[c] before the edge: start is rejected (REQ-023), finish completes.
REQ-028 W1C: writing 1 to INT_STAT/ERR_STAT bits clears them; a set event in the same cycle SHALL win over the clear.
REQ-029 INT SHALL equal registered |(INT_STAT & INT_EN[N_CH-1:0]), one cycle after the status update.
REQ-030 INT_EN bits above N_CH-1, and INT_STAT/ERR_STAT unused bits, SHALL read 0.
REQ-031 Write CTRL bit0=1 SHALL pulse SOFT_RESET for 1 cycle and clear busy, INT_STAT, ERR_STAT and pending START on the same edge; CFG and INT_EN SHALL be retained.
REQ-032 CTRL write with bit0=1 and START write cannot coincide (one access per cycle); FINISH during soft-reset cycle SHALL be ignored.

Reset
REQ-033 On RESET=1 at a clock edge all state SHALL clear: RDATA=0, INT=0, SOFT_RESET=0, START=0, CFG=0, busy=0, INT_STAT=0, INT_EN=0, ERR_STAT=0.
REQ-034 RESET asserted mid-operation SHALL abandon all busy channels with no interrupt; FINISH pulses during reset SHALL be ignored.

Verification
REQ-035 Write 0x1234_5678 to 0x144 (ch1 r1), read 0x144 -> RDATA=0x1234_5678 next cycle; CFG bits [(1*8+1)*32 +: 32] equal it.
REQ-036 INT_EN=0x1, START=0x1 -> START[0] 1-cycle pulse, STATUS=0x1; FINISH[0] -> STATUS=0x0, INT_STAT=0x1, INT=1; write INT_STAT=0x1 -> INT=0.
REQ-037 ch2 busy; write START=0x4 -> no pulse, ERR_STAT=0x4; write 0x180 -> CFG unchanged, ERR_STAT=0x404.
REQ-038 Same cycle FINISH[0] and W1C of INT_STAT bit0 -> INT_STAT bit0 remains 1.
REQ-039 Channels 0 and 3 busy, write CTRL=0x1 -> SOFT_RESET pulse, STATUS=0, INT_STAT=0, CFG and INT_EN unchanged; read 0x018 -> 0x0002_0000.
REQ-040 Assert RESET while ch0 busy, then FINISH[0] -> STATUS=0, INT_STAT=0, INT=0; read 0x3FC -> 0.
